// File: rtl/fix_conv_arbiter.sv
// fix_conv_arbiter: round-robin two-requester 3-digit ASCII-to-binary converter
// Ports: clk, rst (sync, active-high); req0_i/data0_i, req1_i/data1_i requests with ASCII digits;
// gnt0_o/gnt1_o grant pulses; done0_o/done1_o completion pulses; result_o shared 10-bit value;
// err_o non-digit flag; busy_o. Define FIX_CONV_ERRCHK_EN to enable non-digit detection.
module fix_conv_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_i,
  input  logic [23:0] data0_i,
  input  logic        req1_i,
  input  logic [23:0] data1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [9:0]  result_o,
  output logic        err_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, D2, D1, D0, DONE} state_t;
  state_t r_state, w_next;
  logic r_ptr, r_id, w_win, w_req;
  logic [23:0] r_data, w_in;
  logic [9:0] r_acc, w_mac, w_res;
  logic [7:0] w_byte, w_sub;
  assign w_req = req0_i | req1_i;
  assign w_win = (req0_i & req1_i) ? r_ptr : req1_i;
  assign w_in = w_win ? data1_i : data0_i;
  assign w_byte = (r_state == D2) ? r_data[23:16] : (r_state == D1) ? r_data[15:8] : r_data[7:0];
  assign w_sub = w_byte - 8'h30;
  // D2 starts a fresh accumulation; later digits multiply-accumulate with 10-bit wrap
  assign w_mac = ((r_state == D2) ? 10'd0 : r_acc * 10'd10) + 10'(w_sub & 8'h0f);
`ifdef FIX_CONV_ERRCHK_EN
  logic r_bad, w_bad_in;
  function automatic logic non_digit(input logic [7:0] b);
    return (b < 8'h30) || (b > 8'h39);
  endfunction
  assign w_bad_in = non_digit(w_in[23:16]) | non_digit(w_in[15:8]) | non_digit(w_in[7:0]);
  assign w_res = r_bad ? 10'd0 : w_mac;
  assign err_o = (r_state == DONE) & r_bad;
  always_ff @(posedge clk)
    if (rst) r_bad <= 1'b0;
    else if (r_state == IDLE && w_req) r_bad <= w_bad_in;
`else
  assign w_res = w_mac;
  assign err_o = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    gnt0_o = (r_state == D2) & ~r_id;
    gnt1_o = (r_state == D2) & r_id;
    done0_o = (r_state == DONE) & ~r_id;
    done1_o = (r_state == DONE) & r_id;
    busy_o = r_state != IDLE;
    case (r_state)
      IDLE: w_next = w_req ? D2 : IDLE;
      D2: w_next = D1;
      D1: w_next = D0;
      D0: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= 1'b0;
      r_id <= 1'b0;
      r_data <= 24'd0;
      r_acc <= 10'd0;
      result_o <= 10'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_data <= w_in;
        r_id <= w_win;
      end
      if (r_state == D2 || r_state == D1 || r_state == D0) r_acc <= w_mac;
      if (r_state == D0) result_o <= w_res;
      if (r_state == DONE) r_ptr <= ~r_id;
    end
endmodule

// File: tb/tb_fix_conv_arbiter.sv
// tb_fix_conv_arbiter: directed bench with a phase-counter reference model checked every cycle
module tb_fix_conv_arbiter;
  logic clk = 0, rst = 1, req0 = 0, req1 = 0;
  logic [23:0] data0 = 0, data1 = 0;
  logic gnt0, gnt1, done0, done1, err, busy;
  logic [9:0] result;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fix_conv_arbiter dut (
    .clk(clk), .rst(rst), .req0_i(req0), .data0_i(data0), .req1_i(req1), .data1_i(data1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
    .result_o(result), .err_o(err), .busy_o(busy)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic int dg(input logic [7:0] b);
    return (int'(b) - 48) & 15;
  endfunction
  function automatic bit nd(input logic [7:0] b);
    return b < 8'h30 || b > 8'h39;
  endfunction
  function automatic bit model_err(input logic [23:0] d);
`ifdef FIX_CONV_ERRCHK_EN
    return nd(d[23:16]) | nd(d[15:8]) | nd(d[7:0]);
`else
    return 0;
`endif
  endfunction
  function automatic int model_res(input logic [23:0] d);
    if (model_err(d)) return 0;
    return (dg(d[23:16]) * 100 + dg(d[15:8]) * 10 + dg(d[7:0])) % 1024;
  endfunction
  int m_phase = 0, m_res = 0;
  bit m_ptr = 0, m_own = 0, m_err = 0, armed = 0;
  logic [23:0] m_data = 0;
  always @(posedge clk)
    if (rst) begin
      m_phase <= 0;
      m_ptr <= 0;
      m_res <= 0;
      armed <= 1;
    end else case (m_phase)
      0: if (req0 || req1) begin
        m_own <= (req0 && req1) ? m_ptr : req1;
        m_data <= ((req0 && req1) ? m_ptr : req1) ? data1 : data0;
        m_phase <= 1;
      end
      3: begin
        m_phase <= 4;
        m_res <= model_res(m_data);
        m_err <= model_err(m_data);
      end
      4: begin
        m_ptr <= !m_own;
        m_phase <= 0;
      end
      default: m_phase <= m_phase + 1;
    endcase
  always @(negedge clk)
    if (armed) begin
      chk("m_gnt0", gnt0, m_phase == 1 && !m_own);
      chk("m_gnt1", gnt1, m_phase == 1 && m_own);
      chk("m_done0", done0, m_phase == 4 && !m_own);
      chk("m_done1", done1, m_phase == 4 && m_own);
      chk("m_busy", busy, m_phase != 0);
      chk("m_result", result, m_res);
      if (m_phase == 4) chk("m_err", err, m_err);
    end
  task automatic conv(input bit who, input logic [23:0] d, input logic [23:0] d_late,
                      input int exp_res, input bit exp_err, input string nm);
    if (who) begin req1 = 1; data1 = d; end else begin req0 = 1; data0 = d; end
    @(negedge clk);
    req0 = 0;
    req1 = 0;
    if (who) data1 = d_late; else data0 = d_late;
    chk({nm, "_gnt"}, who ? gnt1 : gnt0, 1);
    repeat (3) @(negedge clk);
    chk({nm, "_done"}, who ? done1 : done0, 1);
    chk({nm, "_res"}, result, exp_res);
    chk({nm, "_err"}, err, exp_err);
    @(negedge clk);
  endtask
  int g[$], r[$];
  int gcount;
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_gnt", gnt0 | gnt1, 0);
    conv(0, "035", "035", 35, 0, "t028");
    rst = 1;
    @(negedge clk);
    rst = 0;
    req0 = 1; req1 = 1; data0 = "999"; data1 = "007";
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (gnt0) g.push_back(0);
      if (gnt1) g.push_back(1);
      if (done0 || done1) r.push_back(int'(result));
      chk("t029_ovl", done0 & done1, 0);
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("t029_ngnt", g.size(), 3);
    chk("t029_nres", r.size(), 3);
    if (g.size() == 3 && r.size() == 3) begin
      chk("t029_g0", g[0], 0); chk("t029_g1", g[1], 1); chk("t029_g2", g[2], 0);
      chk("t029_r0", r[0], 999); chk("t029_r1", r[1], 7); chk("t029_r2", r[2], 999);
    end
    req0 = 1; data0 = "250";
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    req1 = 1; data1 = "111";
    @(negedge clk);
    req1 = 0;
    @(negedge clk);
    chk("t030_done", done0, 1);
    chk("t030_res", result, 250);
    gcount = 0;
    repeat (5) begin
      @(negedge clk);
      gcount += int'(gnt1) + int'(busy);
    end
    chk("t030_nognt1", gcount, 0);
    req0 = 1; data0 = "123";
    @(negedge clk);
    req0 = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t031_busy", busy, 0);
    chk("t031_done", done0 | done1, 0);
    chk("t031_res", result, 0);
    conv(0, "042", "042", 42, 0, "t031b");
`ifdef FIX_CONV_ERRCHK_EN
    conv(0, "1A3", "1A3", 0, 1, "t032");
`else
    conv(0, "1A3", "1A3", 113, 0, "t032");
`endif
    conv(0, "123", "456", 123, 0, "t033");
    conv(1, "500", "500", 500, 0, "t_req1");
    conv(1, "000", "000", 0, 0, "t_zero");
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fix_conv_arbiter.md
FIX_CONV_ARBITER -- requirements
Module: fix_conv_arbiter

Interface
REQ-001 The block SHALL have no parameters: digit count fixed at 3, result width fixed at 10 bits.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_i  input  1  requester 0 (tag path) conversion request, level.
REQ-005 data0_i  input  24  requester 0 ASCII digits; [23:16] hundreds, [15:8] tens, [7:0] units.
REQ-006 req1_i  input  1  requester 1 (body-length path) conversion request, level.
REQ-007 data1_i  input  24  requester 1 ASCII digits, same packing as data0_i.
REQ-008 gnt0_o / gnt1_o  output  1 each  one-cycle grant pulse to the winning requester.
REQ-009 done0_o / done1_o  output  1 each  one-cycle completion pulse to the owning requester.
REQ-010 result_o  output  10  binary value of the last completed conversion, shared.
REQ-011 err_o  output  1  non-digit flag, valid while done0_o or done1_o is high.
REQ-012 busy_o  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, D2, D1, D0, DONE. Transitions: IDLE->D2 when any request is sampled; D2->D1->D0->DONE unconditionally; DONE->IDLE.
REQ-014 In IDLE, on the edge where req0_i or req1_i is high, the block SHALL latch the winner's 24-bit data and winner ID.
REQ-015 Arbitration SHALL be round-robin: single request wins outright; on simultaneous requests the requester selected by the priority pointer wins.
REQ-016 The priority pointer SHALL move to the non-winner in DONE, so with both requests held continuously, grants alternate 0,1,0,1.
REQ-017 gntX_o SHALL be high for exactly the D2 cycle of requester X's conversion; requester X SHALL drop reqX_i in that cycle, otherwise it is re-arbitrated on return to IDLE.
REQ-018 A request withdrawn before being sampled in IDLE SHALL be ignored; req is not sampled outside IDLE.
REQ-019 Datapath: D2 acc = h; D1 acc = acc*10 + t; D0 acc = acc*10 + u; digit = byte - 0x30; arithmetic is 10-bit, maximum 999.
REQ-020 In DONE, doneX_o for the latched winner SHALL be high for one cycle; result_o SHALL update on entry to DONE and hold until the next DONE.
REQ-021 Latency: request sampled at edge N -> gnt at cycle N+1 -> done at cycle N+4; throughput one conversion per 5 cycles.
REQ-022 Changes to dataX_i after the sampling edge SHALL NOT affect the conversion in progress.
REQ-023 gnt0_o/gnt1_o SHALL never both be high; the same applies to done0_o/done1_o.

Reset
REQ-024 While rst is high at a rising edge: state <= IDLE, pointer <= requester 0, acc and result_o <= 0, all grant/done/err/busy outputs 0.
REQ-025 Reset mid-conversion SHALL abort it with no done pulse; the first request sampled after reset starts a fresh conversion.

Configuration
REQ-026 With FIX_CONV_ERRCHK_EN defined, any latched byte outside 0x30-0x39 SHALL set err_o in DONE and force result_o to 0.
REQ-027 Without FIX_CONV_ERRCHK_EN, err_o SHALL be tied 0 and each digit value SHALL be the low 4 bits of (byte - 0x30), with 10-bit wrap-around accumulation.

Verification
REQ-028 req0_i=1, data0_i="035" -> gnt0_o at N+1, done0_o at N+4, result_o=35, err_o=0.
REQ-029 req0_i and req1_i both held with "999"/"007" after reset -> grant order 0,1,0; results 999, 7, 999; no overlapping done pulses.
REQ-030 req1_i pulses during D1 of a requester-0 conversion, then drops -> ignored, no gnt1_o.
REQ-031 rst asserted in D0 -> no done pulse, busy_o=0, result_o=0 next cycle; a new request then completes normally.
REQ-032 FIX_CONV_ERRCHK_EN defined, data0_i="1A3" -> done0_o with err_o=1, result_o=0; macro undefined -> err_o=0, result_o=((1*10+0x11 mod 16)*10+3)=113.
REQ-033 data0_i changed from "123" to "456" in the cycle after sampling -> result_o=123.
